gpio_seq_checker: RTL and testbench
===================================

# gpio_seq_checker

Receive-side counterpart of the walking-one GPIO sequencer: samples the 34 breakout GPIO inputs, verifies a one-hot sequence pin 0 → pin 33 where each pin stays high for prescaler ms, then raises `done` with a pass/fail verdict. It sits in a team project slot alongside the sequencer (looped back on the board) and reports status to the management core through the LA and the `done` interrupt.

## Interface
- `CYC_PER_MS`, default 10000: clock cycles per ms (10 MHz clock); the bench overrides it with small values.
- `TOL`, default 16: allowed dwell error, ± cycles.
- `clk`, input, 1: system clock, 10 MHz.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `en`, input, 1: chip enable; low forces idle.
- `prescaler`, input, 14: expected dwell per pin in ms, from Wishbone.
- `done`, output, 1: verdict available (interrupt).
- `la_data_in`, input, 128: LA inputs.
- `la_oenb`, input, 128: LA output enables, active low.
- `la_data_out`, output, 128: status word.
- `gpio_in`, input, 34: pins under check.
- `gpio_out`, output, 34: always 0.
- `gpio_oeb`, output, 34: always all ones, so every pin is an input.

## Operation
- Control decode:
  - `arm = en & ~la_oenb[0] & la_data_in[0]`.
  - `clear = en & ~la_oenb[1] & la_data_in[1]`.
  - `clear` has priority over `arm`.
- Input conditioning: `gpio_in` passes through a 2-flop synchronizer, giving `s`. All checks use `s`.
- Target dwell: `target = {14'd0, prescaler} * CYC_PER_MS`, 28 bits.
  - `lo = target - TOL`, saturating at 0.
  - `hi = target + TOL`.
- Registered state: `idx` (6 b), `dwell` (28 b, saturating), `err_code` (3 b), `last_dwell` (28 b).
- Error codes: 0 none, 1 TOO_SHORT, 2 TOO_LONG, 3 BAD_PATTERN, 4 BAD_CONFIG.
- State IDLE:
  - `arm` with `prescaler == 0` → FAIL, code 4.
  - `arm` otherwise → WAIT_FIRST, with `idx = 0` and `dwell = 0`.
- State WAIT_FIRST:
  - `s == 0` → stay.
  - `s == 34'b1` → TRACK, with `dwell = 1`.
  - Any other value → FAIL, code 3, `idx = 0`.
- State TRACK. Let `E = 1 << idx`.
  - `s == E`, `dwell < hi` → `dwell++`.
  - `s == E`, `dwell == hi` → FAIL, code 2, `last_dwell = hi + 1`.
  - Legal successor → check the dwell.
    - Legal successor is `s == E << 1` when `idx < 33`, or `s == 0` when `idx == 33`.
    - Set `last_dwell = dwell`.
    - `dwell < lo` → FAIL, code 1.
    - Otherwise, `idx == 33` → DONE.
    - Otherwise `idx++` and `dwell = 1`.
  - Any other value → FAIL, code 3, `idx` unchanged.
- State DONE: `done = 1`, pass = 1. Holds until `clear`.
- State FAIL: `done = 1`, pass = 0. `idx`, `err_code` and `last_dwell` are frozen. Holds until `clear`.
- `arm` is ignored outside IDLE.
- `clear` in any state → IDLE and clears `idx`, `dwell`, `err_code`, `last_dwell`.
- `en == 0` behaves like `clear`, and also forces `done = 0` and `la_data_out = 0` combinationally.
- `la_data_out` status word:
  - [0] busy (WAIT_FIRST or TRACK).
  - [1] done.
  - [2] pass.
  - [8:3] `idx`.
  - [11:9] `err_code`.
  - [39:12] `last_dwell`.
  - [127:40] = 0.

## Timing
- Reset (`rst` sampled high at a `clk` edge):
  - State IDLE; all registers and synchronizer flops 0.
  - `done = 0`; `la_data_out = 0`.
  - `gpio_out = 0`; `gpio_oeb = '1`.
  - Reset mid-sequence aborts with no verdict.
- Latency:
  - Pin edge → `s` takes 2 cycles; `s` → state change takes 1 cycle.
  - `done` rises 3 cycles after `gpio_in[33]` falls in a passing run.
- Dwell counts cycles with `s == E`, so an ideal pin high for N cycles measures `dwell = N`.
- TOO_LONG fires in the cycle after `dwell` reaches `hi`. It does not wait for the edge.
- `done` is level: it stays high from DONE/FAIL entry until `clear`, `en` low or `rst`.
- A glitch of one cycle on any other pin during TRACK gives BAD_PATTERN. There is no filtering beyond the synchronizer.
- The 28-bit product must not overflow. The maximum 16383 × 10000 is below 2^28.

## Test plan
All scenarios use `CYC_PER_MS = 10`, `TOL = 2`, `prescaler = 3`, so `target = 30`.
1. Arm, then an ideal walking one with 30 cycles per pin, pins 0..33, then all low → 3 cycles after pin 33 falls: `done = 1`, `la[2] = 1`, `idx = 33`, `last_dwell = 30`, `err = 0`.
2. Same, but pin 5 held 40 cycles → FAIL with `err = 2`, `idx = 5`, `last_dwell = 33`; `done = 1`, `la[2] = 0`.
3. Pin 12 held 25 cycles, then pin 13 → FAIL with `err = 1`, `idx = 12`, `last_dwell = 25`.
4. Pins 7 and 8 both high while tracking pin 7 → FAIL with `err = 3`, `idx = 7`. In a separate run, first pattern `34'h2` → `err = 3`, `idx = 0`.
5. Arm with `prescaler = 0` → FAIL with `err = 4` in 1 cycle. Assert `clear` → IDLE, `done = 0`.
6. Mid-sequence at pin 20: (a) `en` low → `done = 0`, `la_data_out = 0` immediately, then IDLE; (b) `rst` high 1 cycle → all outputs at reset values; (c) re-arm plus an ideal run → pass.

Source files
------------

// File: rtl/gpio_seq_checker.sv
// Receive-side walking-one checker: verifies pins 0..33 go high one at a time,
// each for prescaler ms within +/-TOL cycles, and reports a pass/fail verdict.
module gpio_seq_checker #(
  parameter int unsigned CYC_PER_MS = 10000,
  parameter int unsigned TOL        = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [13:0]  prescaler,
  output logic         done,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  input  logic [33:0]  gpio_in,
  output logic [33:0]  gpio_out,
  output logic [33:0]  gpio_oeb
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FIRST,
    ST_TRACK,
    ST_DONE,
    ST_FAIL
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_SHORT   = 3'd1;
  localparam logic [2:0] ERR_LONG    = 3'd2;
  localparam logic [2:0] ERR_PATTERN = 3'd3;
  localparam logic [2:0] ERR_CONFIG  = 3'd4;
  localparam logic [5:0] LAST_IDX    = 6'd33;
  localparam logic [33:0] FIRST_PAT  = 34'd1;

  state_e      state_q;
  logic [33:0] sync_q;
  logic [33:0] s_q;
  logic [5:0]  idx_q;
  logic [27:0] dwell_q;
  logic [27:0] last_dwell_q;
  logic [2:0]  err_q;

  logic        arm;
  logic        clear;
  logic        hold_e;
  logic        succ;
  logic        busy;
  logic        verdict;
  logic        pass;
  logic [33:0] exp_e;
  logic [27:0] target;
  logic [27:0] lo;
  logic [27:0] hi;
  logic        unused_la;

  assign arm   = en & ~la_oenb[0] & la_data_in[0];
  // Dropping en is folded into clear so the FSM has a single abort path.
  assign clear = ~en | (~la_oenb[1] & la_data_in[1]);

  assign target = {14'd0, prescaler} * 28'(CYC_PER_MS);
  assign lo     = (target > 28'(TOL)) ? (target - 28'(TOL)) : '0;
  assign hi     = target + 28'(TOL);

  assign exp_e  = FIRST_PAT << idx_q;
  assign hold_e = (s_q == exp_e);
  assign succ   = (idx_q < LAST_IDX) ? (s_q == (exp_e << 1)) : (s_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_q    <= '0;
    end else begin
      sync_q <= gpio_in;
      s_q    <= sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      dwell_q      <= '0;
      err_q        <= ERR_NONE;
      last_dwell_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            if (prescaler == '0) begin
              state_q <= ST_FAIL;
              err_q   <= ERR_CONFIG;
            end else begin
              state_q <= ST_WAIT_FIRST;
              idx_q   <= '0;
              dwell_q <= '0;
            end
          end
        end
        ST_WAIT_FIRST: begin
          if (s_q == FIRST_PAT) begin
            state_q <= ST_TRACK;
            dwell_q <= 28'd1;
          end else if (s_q != '0) begin
            state_q <= ST_FAIL;
            err_q   <= ERR_PATTERN;
            idx_q   <= '0;
          end
        end
        ST_TRACK: begin
          if (hold_e) begin
            // Too long is flagged as soon as the window is exceeded, not at the edge.
            if (dwell_q >= hi) begin
              state_q      <= ST_FAIL;
              err_q        <= ERR_LONG;
              last_dwell_q <= hi + 28'd1;
            end else begin
              dwell_q <= dwell_q + 28'd1;
            end
          end else if (succ) begin
            last_dwell_q <= dwell_q;
            if (dwell_q < lo) begin
              state_q <= ST_FAIL;
              err_q   <= ERR_SHORT;
            end else if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + 6'd1;
              dwell_q <= 28'd1;
            end
          end else begin
            state_q <= ST_FAIL;
            err_q   <= ERR_PATTERN;
          end
        end
        ST_DONE, ST_FAIL: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q == ST_WAIT_FIRST) || (state_q == ST_TRACK);
  assign verdict = (state_q == ST_DONE) || (state_q == ST_FAIL);
  assign pass    = (state_q == ST_DONE);

  assign done        = en & verdict;
  assign la_data_out = en ? {88'd0, last_dwell_q, err_q, idx_q, pass, verdict, busy} : '0;

  assign gpio_out = '0;
  assign gpio_oeb = '1;

  assign unused_la = ^{la_data_in[127:2], la_oenb[127:2]};

endmodule

// File: tb/tb_gpio_seq_checker.sv
// Directed bench for gpio_seq_checker: table of whole-sequence scenarios plus
// hand-written reset, config, latency and abort sequences.
module tb_gpio_seq_checker;

  logic         clk;
  logic         rst;
  logic         en;
  logic [13:0]  prescaler;
  logic         done;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;
  logic [33:0]  gpio_in;
  logic [33:0]  gpio_out;
  logic [33:0]  gpio_oeb;

  int total = 0;
  int bad   = 0;

  gpio_seq_checker #(.CYC_PER_MS(10), .TOL(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .prescaler  (prescaler),
    .done       (done),
    .la_data_in (la_data_in),
    .la_oenb    (la_oenb),
    .la_data_out(la_data_out),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_oeb   (gpio_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          first_bad;
    int          bad_pin;
    int          bad_len;
    int          glitch_pin;
    logic        exp_pass;
    logic [2:0]  exp_err;
    logic [5:0]  exp_idx;
    logic [27:0] exp_last;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [127:0] status(input logic busy, input logic dn, input logic ps,
                                          input logic [5:0] idx, input logic [2:0] err,
                                          input logic [27:0] last);
    return {88'd0, last, err, idx, ps, dn, busy};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic arm_pulse();
    la_data_in[0] = 1'b1;
    la_oenb[0]    = 1'b0;
    cycles(1);
    la_data_in[0] = 1'b0;
    la_oenb[0]    = 1'b1;
  endtask

  task automatic clear_pulse();
    la_data_in[1] = 1'b1;
    la_oenb[1]    = 1'b0;
    cycles(1);
    la_data_in[1] = 1'b0;
    la_oenb[1]    = 1'b1;
  endtask

  task automatic walk(input int last_pin, input int bad_pin, input int bad_len, input int glitch_pin);
    for (int p = 0; p <= last_pin; p++) begin
      int n;
      n = (p == bad_pin) ? bad_len : 30;
      gpio_in = 34'd1 << p;
      if (p == glitch_pin) begin
        cycles(10);
        gpio_in = (34'd1 << p) | (34'd1 << (p + 1));
        cycles(1);
        gpio_in = 34'd1 << p;
        cycles(n - 11);
      end else begin
        cycles(n);
      end
    end
  endtask

  initial begin
    vecs[0] = '{0, -1, 30, -1, 1'b1, 3'd0, 6'd33, 28'd30};
    vecs[1] = '{0,  5, 40, -1, 1'b0, 3'd2, 6'd5,  28'd33};
    vecs[2] = '{0, 12, 25, -1, 1'b0, 3'd1, 6'd12, 28'd25};
    vecs[3] = '{0, -1, 30,  7, 1'b0, 3'd3, 6'd7,  28'd30};
    vecs[4] = '{1, -1, 30, -1, 1'b0, 3'd3, 6'd0,  28'd0};
    vecs[5] = '{0,  3, 28, -1, 1'b1, 3'd0, 6'd33, 28'd30};
    vecs[6] = '{0, 33, 32, -1, 1'b1, 3'd0, 6'd33, 28'd32};
    vecs[7] = '{0, 33, 33, -1, 1'b0, 3'd2, 6'd33, 28'd33};
    vecs[8] = '{0, 10, 27, -1, 1'b0, 3'd1, 6'd10, 28'd27};

    rst        = 1'b1;
    en         = 1'b1;
    prescaler  = 14'd3;
    la_data_in = '0;
    la_oenb    = '1;
    gpio_in    = '0;
    cycles(2);
    rst = 1'b0;

    chk("reset_done", 128'(done), 128'd0);
    chk("reset_la", la_data_out, '0);
    chk("reset_gpio_out", 128'(gpio_out), 128'd0);
    chk("reset_gpio_oeb", 128'(gpio_oeb), 128'(34'h3_ffff_ffff));

    for (int i = 0; i < 9; i++) begin
      clear_pulse();
      gpio_in = '0;
      cycles(3);
      arm_pulse();
      if (vecs[i].first_bad != 0) begin
        gpio_in = 34'h2;
        cycles(5);
      end else begin
        walk(33, vecs[i].bad_pin, vecs[i].bad_len, vecs[i].glitch_pin);
      end
      gpio_in = '0;
      cycles(4);
      chk($sformatf("vec%0d_done", i), 128'(done), 128'd1);
      chk($sformatf("vec%0d_status", i), la_data_out,
          status(1'b0, 1'b1, vecs[i].exp_pass, vecs[i].exp_idx, vecs[i].exp_err, vecs[i].exp_last));
    end

    // Zero prescaler is rejected at arm time.
    clear_pulse();
    prescaler = 14'd0;
    arm_pulse();
    chk("cfg_done", 128'(done), 128'd1);
    chk("cfg_status", la_data_out, status(1'b0, 1'b1, 1'b0, 6'd0, 3'd4, 28'd0));
    prescaler = 14'd3;
    clear_pulse();
    chk("cfg_clear_done", 128'(done), 128'd0);
    chk("cfg_clear_la", la_data_out, '0);

    // en dropped while tracking pin 20.
    cycles(2);
    arm_pulse();
    walk(19, -1, 30, -1);
    gpio_in = 34'd1 << 20;
    cycles(10);
    chk("mid_busy", la_data_out, status(1'b1, 1'b0, 1'b0, 6'd20, 3'd0, 28'd30));
    en = 1'b0;
    #1;
    chk("en_low_done", 128'(done), 128'd0);
    chk("en_low_la", la_data_out, '0);
    cycles(1);
    en = 1'b1;
    #1;
    chk("en_low_idle", la_data_out, '0);
    gpio_in = '0;
    cycles(3);

    // Reset while tracking pin 20.
    arm_pulse();
    walk(19, -1, 30, -1);
    gpio_in = 34'd1 << 20;
    cycles(10);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("midrst_done", 128'(done), 128'd0);
    chk("midrst_la", la_data_out, '0);
    chk("midrst_gpio_out", 128'(gpio_out), 128'd0);
    chk("midrst_gpio_oeb", 128'(gpio_oeb), 128'(34'h3_ffff_ffff));

    // Re-arm and pass, checking the 3-cycle verdict latency.
    gpio_in = '0;
    cycles(3);
    arm_pulse();
    walk(33, -1, 30, -1);
    gpio_in = '0;
    cycles(2);
    chk("latency_early", 128'(done), 128'd0);
    cycles(1);
    chk("latency_done", 128'(done), 128'd1);
    chk("rearm_status", la_data_out, status(1'b0, 1'b1, 1'b1, 6'd33, 3'd0, 28'd30));
    cycles(5);
    chk("done_level", 128'(done), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
